piso_stream: RTL and testbench

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order and a bit-rate enable. It is the next generation of the team's 4-bit load/shift PISO. It sits between a word-wide producer (FIFO, register bank, FSM) and a single-wire serial consumer. It supports back-to-back words with no idle bit between them, and it reports busy and per-word completion.

---
 rtl/piso_stream.sv | 106 ++++++++++
 tb/tb_piso_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order
// and a bit-rate enable. Back-to-back words are chained on the last-bit edge without a gap.
module piso_stream #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    // Handshake: a word is taken on any rising edge where in_valid && in_ready; the producer
    // holds parallel_in and in_valid stable until then, and parallel_in is ignored otherwise.

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             done_q;
    logic             last_bit;
    logic             accept;

    // The last bit is consumed on this edge, so a new word may be loaded in the same edge.
    assign last_bit = (state == SHIFT) && (cnt == CW'(1)) && shift_en;
    assign in_ready = !rst && ((state == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit && !accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        serial_out   = IDLE_LEVEL;
        serial_valid = 1'b0;
        busy         = 1'b0;
        if (state == SHIFT) begin
            serial_out   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
            serial_valid = 1'b1;
            busy         = 1'b1;
        end
    end

    assign done = done_q;

    // Datapath: shift register, remaining-bit counter and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_bit;
            if (accept) begin
                sreg <= parallel_in;
                cnt  <= CW'(WIDTH);
            end else if ((state == SHIFT) && shift_en) begin
                if (cnt > CW'(1)) begin
                    sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                    cnt  <= cnt - CW'(1);
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: an MSB-first and an LSB-first instance share one stimulus,
// and each serialized word is compared against hand-written bit sequences.
module tb_piso_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] parallel_in;
    logic       in_valid;
    logic       shift_en;

    logic m_ready, m_out, m_valid, m_busy, m_done;
    logic l_ready, l_out, l_valid, l_busy, l_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk         (clk),
        .rst         (rst),
        .parallel_in (parallel_in),
        .in_valid    (in_valid),
        .in_ready    (m_ready),
        .shift_en    (shift_en),
        .serial_out  (m_out),
        .serial_valid(m_valid),
        .busy        (m_busy),
        .done        (m_done)
    );

    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk         (clk),
        .rst         (rst),
        .parallel_in (parallel_in),
        .in_valid    (in_valid),
        .in_ready    (l_ready),
        .shift_en    (shift_en),
        .serial_out  (l_out),
        .serial_valid(l_valid),
        .busy        (l_busy),
        .done        (l_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] w);
        parallel_in = w;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    // Eight bit cycles with shift_en high; sequences list the first serial bit at [7].
    task automatic word_loop(input string tag, input logic [7:0] mseq, input logic [7:0] lseq,
                             input logic first_done);
        for (int i = 0; i < 8; i++) begin
            check_eq({tag, "_mbit"}, m_out, mseq[7-i]);
            check_eq({tag, "_lbit"}, l_out, lseq[7-i]);
            check_eq({tag, "_valid"}, {m_valid, l_valid, m_busy, l_busy}, 4'hF);
            check_eq({tag, "_ready"}, {m_ready, l_ready}, (i == 7) ? 2'b11 : 2'b00);
            check_eq({tag, "_done"}, {m_done, l_done}, (i == 0 && first_done) ? 2'b11 : 2'b00);
            tick();
        end
    endtask

    task automatic after_word(input string tag);
        check_eq({tag, "_done_pulse"}, {m_done, l_done}, 2'b11);
        check_eq({tag, "_idle_valid"}, {m_valid, l_valid, m_busy, l_busy}, 4'h0);
        check_eq({tag, "_idle_out"}, {m_out, l_out}, 2'b00);
        check_eq({tag, "_idle_ready"}, {m_ready, l_ready}, 2'b11);
        tick();
        check_eq({tag, "_done_clear"}, {m_done, l_done}, 2'b00);
    endtask

    initial begin
        logic [7:0] chg [8];
        chg = '{8'hFF, 8'h00, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h99, 8'h1E};

        rst         = 1'b1;
        parallel_in = 8'h00;
        in_valid    = 1'b0;
        shift_en    = 1'b1;
        tick();
        tick();
        check_eq("rst_ready_low", {m_ready, l_ready}, 2'b00);
        rst = 1'b0;
        #1;
        check_eq("reset_ready", {m_ready, l_ready}, 2'b11);
        check_eq("reset_out", {m_out, l_out}, 2'b00);
        check_eq("reset_valid_busy", {m_valid, l_valid, m_busy, l_busy}, 4'h0);
        check_eq("reset_done", {m_done, l_done}, 2'b00);

        // Single word 0xA5 (palindrome in both orders)
        load(8'hA5);
        word_loop("a5", 8'hA5, 8'hA5, 1'b0);
        after_word("a5");

        // 0x01: MSB-first 00000001, LSB-first 10000000
        load(8'h01);
        word_loop("w01", 8'h01, 8'h80, 1'b0);
        after_word("w01");

        // Back-to-back 0xA5 then 0x3C with in_valid held high
        parallel_in = 8'hA5;
        in_valid    = 1'b1;
        tick();
        parallel_in = 8'h3C;
        word_loop("b2b_1", 8'hA5, 8'hA5, 1'b0);
        in_valid = 1'b0;
        word_loop("b2b_2", 8'h3C, 8'h3C, 1'b1);
        after_word("b2b");

        // Gated bit rate: shift_en 0,1,0,1... from the first bit, each bit held two cycles
        load(8'hC3);
        for (int c = 0; c < 16; c++) begin
            shift_en = c[0];
            #1;
            check_eq("gate_mbit", m_out, ((8'hC3 >> (7 - c / 2)) & 1));
            check_eq("gate_lbit", l_out, ((8'hC3 >> (c / 2)) & 1));
            check_eq("gate_done", {m_done, l_done}, 2'b00);
            if (c >= 14) begin
                check_eq("gate_ready", {m_ready, l_ready}, (c == 15) ? 2'b11 : 2'b00);
            end
            tick();
        end
        shift_en = 1'b1;
        after_word("gate");

        // Reset during bit 4 of 0xFF abandons the word
        load(8'hFF);
        tick();
        tick();
        tick();
        check_eq("rst_mid_bit4", {m_out, l_out, m_busy, l_busy}, 4'hF);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_ready_low", {m_ready, l_ready}, 2'b00);
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_mid_out", {m_out, l_out}, 2'b00);
        check_eq("rst_mid_busy", {m_busy, l_busy, m_valid, l_valid}, 4'h0);
        check_eq("rst_mid_done", {m_done, l_done}, 2'b00);
        check_eq("rst_mid_ready", {m_ready, l_ready}, 2'b11);
        tick();
        check_eq("rst_mid_no_done", {m_done, l_done}, 2'b00);
        load(8'h81);
        word_loop("w81", 8'h81, 8'h81, 1'b0);
        after_word("w81");

        // in_valid held while busy with parallel_in changing every cycle
        load(8'h66);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            parallel_in = chg[i];
            #1;
            check_eq("chg_mbit", m_out, ((8'h66 >> (7 - i)) & 1));
            check_eq("chg_lbit", l_out, ((8'h66 >> i) & 1));
            check_eq("chg_ready", {m_ready, l_ready}, (i == 7) ? 2'b11 : 2'b00);
            tick();
        end
        in_valid    = 1'b0;
        parallel_in = 8'hE7;
        // 0x1E: MSB-first 00011110, LSB-first 01111000
        word_loop("w1e", 8'h1E, 8'h78, 1'b1);
        after_word("w1e");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
